serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB first, one bit per clock, then present {C_out, S} with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  // Full-adder cell on the current LSBs and the carry flop.
  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    sum_d   = a_q[0] ^ b_q[0] ^ c_q;
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    res_d   = {sum_d, res_q[WIDTH-1:1]};
  end

  // Handshake: start is a level sampled only in IDLE or DONE; once accepted,
  // busy stays high for exactly WIDTH cycles and done then pulses for one
  // cycle while S/C_out already hold the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= carry_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            s_q     <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S           = s_q;
  assign C_out       = cout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases plus
// random operands checked against plain integer addition.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic         C_out;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int checks;
  int errors;
  int exp_dones;
  int seen_dones;
  logic [W:0] last_res;

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .S           (S),
    .C_out       (C_out),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) seen_dones++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation. inject_at >= 0 drives start=1 with A=0x11/B=0x22 in that
  // RUN cycle; noise scrambles start/A/B every RUN cycle; hold keeps start high.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inject_at, input bit noise, input bit hold,
                       input string name);
    logic [W:0] exp;
    exp   = {1'b0, a} + {1'b0, b};
    start = 1'b1;
    A     = a;
    B     = b;
    tick();
    if (!hold) start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags cyc%0d: busy=%b done=%b required busy=1 done=0",
                 name, i, busy, done);
      end
      checks++;
      if ({C_out, S} !== last_res) begin
        errors++;
        $display("FAIL %s hold_result cyc%0d: actual=%h required=%h",
                 name, i, {C_out, S}, last_res);
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        A     = W'($urandom);
        B     = W'($urandom);
      end else if (i == inject_at) begin
        start = 1'b1;
        A     = 8'h11;
        B     = 8'h22;
      end else if (!hold) begin
        start = 1'b0;
      end
      tick();
    end
    if (!hold) start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: busy=%b done=%b required busy=0 done=1", name, busy, done);
    end
    checks++;
    if ({C_out, S} !== exp) begin
      errors++;
      $display("FAIL %s result: actual=%h required=%h (A=%h B=%h)", name, {C_out, S}, exp, a, b);
    end
    exp_dones++;
    last_res = exp;
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {C_out, S} !== last_res) begin
        errors++;
        $display("FAIL %s idle cyc%0d: busy=%b done=%b res=%h required 0 0 %h",
                 name, i, busy, done, {C_out, S}, last_res);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({busy, done, C_out, S} !== '0) begin
      errors++;
      $display("FAIL reset_async: actual=%h required=0", {busy, done, C_out, S});
    end
    tick();
    tick();
    #2 reset = 1'b0;
    last_res = '0;
    idle_cycles(2, "post_reset");
  endtask

  task automatic test_zero();
    do_op(8'h00, 8'h00, -1, 1'b0, 1'b0, "zero");
    idle_cycles(2, "zero");
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, -1, 1'b0, 1'b0, "ff_plus_1");
    idle_cycles(1, "ff_plus_1");
    do_op(8'hFF, 8'hFF, -1, 1'b0, 1'b0, "ff_plus_ff");
    idle_cycles(1, "ff_plus_ff");
  endtask

  task automatic test_ignore_start();
    do_op(8'h5A, 8'h3C, 3, 1'b0, 1'b0, "ignore_start");
    checks++;
    if ({C_out, S} !== 9'h096) begin
      errors++;
      $display("FAIL ignore_start const: actual=%h required=096", {C_out, S});
    end
    idle_cycles(2, "ignore_start");
  endtask

  task automatic test_back_to_back();
    do_op(8'hC8, 8'h64, -1, 1'b0, 1'b1, "b2b_first");
    do_op(8'hC8, 8'h64, -1, 1'b0, 1'b0, "b2b_second");
    checks++;
    if ({C_out, S} !== 9'h12C) begin
      errors++;
      $display("FAIL b2b const: actual=%h required=12c", {C_out, S});
    end
    idle_cycles(2, "b2b");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    A     = 8'h5A;
    B     = 8'h3C;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, C_out, S} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: actual busy=%b done=%b res=%h required all 0",
               busy, done, {C_out, S});
    end
    tick();
    #2 reset = 1'b0;
    last_res = '0;
    idle_cycles(10, "after_abort");
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 1000; n++) begin
      do_op(W'($urandom), W'($urandom), -1, 1'($urandom_range(0, 1)), 1'b0, "random");
      gap = $urandom_range(0, 2);
      if (gap != 0) idle_cycles(gap, "random");
    end
    idle_cycles(2, "random_end");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_dones  = 0;
    seen_dones = 0;
    last_res   = '0;
    start      = 1'b0;
    A          = '0;
    B          = '0;
    test_reset();
    test_zero();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    checks++;
    if (seen_dones !== exp_dones) begin
      errors++;
      $display("FAIL done_count: actual=%0d required=%0d", seen_dones, exp_dones);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
